// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI read/write arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_START = 3'd1,
    ST_WR_RUN   = 3'd2,
    ST_RD_START = 3'd3,
    ST_RD_RUN   = 3'd4
  } arb_state_e;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  // True while the given direction owns the AXI port (granted or running).
  function automatic logic dir_active(input arb_state_e s, input logic dir);
    logic act;
    if (dir == DIR_WR) begin
      act = (s == ST_WR_START) || (s == ST_WR_RUN);
    end else begin
      act = (s == ST_RD_START) || (s == ST_RD_RUN);
    end
    return act;
  endfunction

endpackage

// File: rtl/axi_rw_arbiter_if.sv
// Handshake bundle between the arbiter and the AXI write/read masters.
interface axi_rw_arbiter_if;
  logic m_wr_start;
  logic m_wr_ready;
  logic m_wr_done;
  logic m_rd_start;
  logic m_rd_ready;
  logic m_rd_done;

  // Arbiter side: issues start, observes ready/done.
  modport master (
    output m_wr_start, m_rd_start,
    input  m_wr_ready, m_wr_done, m_rd_ready, m_rd_done
  );

  // AXI master side: receives start, reports ready/done.
  modport slave (
    input  m_wr_start, m_rd_start,
    output m_wr_ready, m_wr_done, m_rd_ready, m_rd_done
  );
endinterface

// File: rtl/arb_timeout_timer.sv
// Grant-to-done watchdog: cleared on load, counts while enabled,
// flags expiry when the count reaches TIMEOUT_CYC-1.
module arb_timeout_timer #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int            TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q;

  // Cycle counter; holds at LAST so it never wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + TW'(1);
    end
  end

  assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/axi_rw_arbiter.sv
// Round-robin time-sharing of the DDR3 AXI port between the write and read
// masters, with completion watchdog and calibration gating.
module axi_rw_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             calib_done,
  input  logic             ctrl_wr_req,
  output logic             ctrl_wr_ready,
  input  logic             ctrl_rd_req,
  output logic             ctrl_rd_ready,
  axi_rw_arbiter_if.master m_if,
  output logic             busy,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_burst_cnt,
  output logic [CNT_W-1:0] rd_burst_cnt
);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             wr_start_q, rd_start_q, busy_q, err_q;
  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic             wr_elig, rd_elig;
  logic             wr_done_evt, rd_done_evt, timeout_evt;
  logic             tmr_load, tmr_en, tmr_expire;

  assign wr_elig = calib_done && ctrl_wr_req && m_if.m_wr_ready;
  assign rd_elig = calib_done && ctrl_rd_req && m_if.m_rd_ready;

  // Controller back-pressure is combinational so a losing request stays pending.
  assign ctrl_wr_ready = calib_done && !dir_active(state_q, DIR_WR);
  assign ctrl_rd_ready = calib_done && !dir_active(state_q, DIR_RD);

  arb_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  // Next-state logic: grant selection, completion and watchdog abort.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_done_evt  = 1'b0;
    rd_done_evt  = 1'b0;
    timeout_evt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_elig && rd_elig) begin
          if (last_grant_q == DIR_RD) begin
            state_d      = ST_WR_START;
            last_grant_d = DIR_WR;
          end else begin
            state_d      = ST_RD_START;
            last_grant_d = DIR_RD;
          end
        end else if (wr_elig) begin
          state_d      = ST_WR_START;
          last_grant_d = DIR_WR;
        end else if (rd_elig) begin
          state_d      = ST_RD_START;
          last_grant_d = DIR_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_START, ST_WR_RUN: begin
        if (m_if.m_wr_done) begin
          state_d     = ST_IDLE;
          wr_done_evt = 1'b1;
        end else if (tmr_expire) begin
          state_d     = ST_IDLE;
          timeout_evt = 1'b1;
        end else if (!m_if.m_wr_ready) begin
          state_d = ST_WR_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RD_START, ST_RD_RUN: begin
        if (m_if.m_rd_done) begin
          state_d     = ST_IDLE;
          rd_done_evt = 1'b1;
        end else if (tmr_expire) begin
          state_d     = ST_IDLE;
          timeout_evt = 1'b1;
        end else if (!m_if.m_rd_ready) begin
          state_d = ST_RD_RUN;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tmr_load = (state_q == ST_IDLE) && (state_d != ST_IDLE);
  assign tmr_en   = (state_q != ST_IDLE);

  // State, grant history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= DIR_RD;
      wr_start_q   <= 1'b0;
      rd_start_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_start_q   <= (state_d == ST_WR_START);
      rd_start_q   <= (state_d == ST_RD_START);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  // Sticky timeout flag; a new timeout outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout_evt) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  // Saturating completed-burst counters; aborted bursts are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (wr_done_evt && (wr_cnt_q != {CNT_W{1'b1}})) begin
        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
      end
      if (rd_done_evt && (rd_cnt_q != {CNT_W{1'b1}})) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

  assign m_if.m_wr_start = wr_start_q;
  assign m_if.m_rd_start = rd_start_q;
  assign busy            = busy_q;
  assign err_timeout     = err_q;
  assign wr_burst_cnt    = wr_cnt_q;
  assign rd_burst_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed bench: instance A (default timeout, 16-bit counters) and
// instance B (TIMEOUT_CYC=16, CNT_W=4) share clock, reset and controller inputs.
module tb_axi_rw_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic calib_done = 1'b0;
  logic wr_req = 1'b0;
  logic rd_req = 1'b0;
  logic err_clr = 1'b0;

  logic        wr_rdy_a, rd_rdy_a, busy_a, err_a;
  logic [15:0] wcnt_a, rcnt_a;
  logic        wr_rdy_b, rd_rdy_b, busy_b, err_b;
  logic [3:0]  wcnt_b, rcnt_b;

  int checks_cnt = 0;
  int errors_cnt = 0;

  axi_rw_arbiter_if ifa ();
  axi_rw_arbiter_if ifb ();

  always #5 clk = ~clk;

  axi_rw_arbiter #(.TIMEOUT_CYC(4096), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .ctrl_wr_req(wr_req), .ctrl_wr_ready(wr_rdy_a),
    .ctrl_rd_req(rd_req), .ctrl_rd_ready(rd_rdy_a),
    .m_if(ifa), .busy(busy_a), .err_timeout(err_a), .err_clr(err_clr),
    .wr_burst_cnt(wcnt_a), .rd_burst_cnt(rcnt_a)
  );

  axi_rw_arbiter #(.TIMEOUT_CYC(16), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .calib_done(calib_done),
    .ctrl_wr_req(wr_req), .ctrl_wr_ready(wr_rdy_b),
    .ctrl_rd_req(rd_req), .ctrl_rd_ready(rd_rdy_b),
    .m_if(ifb), .busy(busy_b), .err_timeout(err_b), .err_clr(err_clr),
    .wr_burst_cnt(wcnt_b), .rd_burst_cnt(rcnt_b)
  );

  // Master models, index 0:A wr 1:A rd 2:B wr 3:B rd.
  // mode 0: ready low 2 cycles after start, done ~20 later; 1: never responds; 2: fast done.
  logic [3:0]  start_v;
  logic [3:0]  ready_v = 4'hF;
  logic [3:0]  done_v = 4'h0;
  int          mcnt [4] = '{0, 0, 0, 0};
  int          mode [4] = '{0, 0, 2, 2};

  assign start_v = {ifb.m_rd_start, ifb.m_wr_start, ifa.m_rd_start, ifa.m_wr_start};
  assign ifa.m_wr_ready = ready_v[0];
  assign ifa.m_rd_ready = ready_v[1];
  assign ifb.m_wr_ready = ready_v[2];
  assign ifb.m_rd_ready = ready_v[3];
  assign ifa.m_wr_done  = done_v[0];
  assign ifa.m_rd_done  = done_v[1];
  assign ifb.m_wr_done  = done_v[2];
  assign ifb.m_rd_done  = done_v[3];

  // Behavioural AXI masters responding to start.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mcnt[i] == 0) begin
        done_v[i] <= 1'b0;
        if (start_v[i] && (mode[i] != 1)) mcnt[i] <= 1;
      end else begin
        mcnt[i] <= mcnt[i] + 1;
        if (mcnt[i] == 2) ready_v[i] <= 1'b0;
        if (mcnt[i] == ((mode[i] == 2) ? 6 : 22)) begin
          done_v[i]  <= 1'b1;
          ready_v[i] <= 1'b1;
        end
        if (mcnt[i] == ((mode[i] == 2) ? 7 : 23)) begin
          done_v[i] <= 1'b0;
          mcnt[i]   <= 0;
        end
      end
    end
  end

  // Grant log for A (0=W, 1=R), idle-gap lengths for A, write-grant count for B.
  logic [1:0] a_start_prev = 2'b00;
  logic       b_wr_prev = 1'b0;
  bit         a_log[$];
  int         a_idle_q[$];
  int         idle_run = 0;
  int         b_wr_grants = 0;

  always @(posedge clk) begin
    a_start_prev <= {ifa.m_rd_start, ifa.m_wr_start};
    b_wr_prev    <= ifb.m_wr_start;
    if (ifa.m_wr_start && !a_start_prev[0]) a_log.push_back(1'b0);
    if (ifa.m_rd_start && !a_start_prev[1]) a_log.push_back(1'b1);
    if (ifb.m_wr_start && !b_wr_prev) b_wr_grants <= b_wr_grants + 1;
    if (!busy_a) begin
      idle_run <= idle_run + 1;
    end else if (idle_run != 0) begin
      a_idle_q.push_back(idle_run);
      idle_run <= 0;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    int         n;
    int         base_log;
    int         base_idle;
    int         base_g;
    logic       flag;
    logic [3:0] seq;

    // Reset state
    @(negedge clk);
    check_val("rst_busy", busy_a, 1'b0);
    check_val("rst_start", {ifa.m_wr_start, ifa.m_rd_start}, 2'b00);
    check_val("rst_err", err_a, 1'b0);
    check_val("rst_cnt", {wcnt_a, rcnt_a}, 32'h0);
    check_val("rst_ctrl_rdy", {wr_rdy_a, rd_rdy_a}, 2'b00);

    // No grants while uncalibrated
    rst_n  = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    flag   = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ifa.m_wr_start || ifa.m_rd_start || busy_a || wr_rdy_a || rd_rdy_a) flag = 1'b1;
    end
    check_val("nocal_quiet", flag, 1'b0);
    base_log   = a_log.size();
    calib_done = 1'b1;
    #1;
    check_val("cal_rdy_comb", {wr_rdy_a, rd_rdy_a}, 2'b11);
    check_val("cal_start_early", ifa.m_wr_start, 1'b0);
    @(negedge clk);
    check_val("cal_first_grant", {ifa.m_wr_start, ifa.m_rd_start}, 2'b10);
    check_val("cal_ctrl_rdy", {wr_rdy_a, rd_rdy_a}, 2'b01);

    // Both requesting: alternation W,R,W,R
    n = 0;
    while (((wcnt_a + rcnt_a) != 16'd4) && (n < 400)) begin
      @(negedge clk);
      n++;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check_val("rr_wait", n < 400, 1'b1);
    check_val("rr_cnts", {wcnt_a, rcnt_a}, {16'd2, 16'd2});
    check_val("rr_ngrants", a_log.size() - base_log, 4);
    seq = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      if (base_log + k < a_log.size()) seq[3-k] = a_log[base_log + k];
    end
    check_val("rr_order", seq, 4'b0101);

    // Write only: 5 grants, one idle cycle between them, read side stays ready
    @(negedge clk);
    base_log  = a_log.size();
    base_idle = a_idle_q.size();
    wr_req    = 1'b1;
    flag      = 1'b0;
    n = 0;
    while ((wcnt_a != 16'd7) && (n < 1000)) begin
      @(negedge clk);
      if (!rd_rdy_a) flag = 1'b1;
      n++;
    end
    wr_req = 1'b0;
    check_val("wo_wait", n < 1000, 1'b1);
    check_val("wo_rd_rdy_drop", flag, 1'b0);
    check_val("wo_ngrants", a_log.size() - base_log, 5);
    flag = 1'b0;
    for (int k = base_log; k < a_log.size(); k++) if (a_log[k]) flag = 1'b1;
    check_val("wo_all_wr", flag, 1'b0);
    flag = (a_idle_q.size() < base_idle + 5);
    for (int k = 1; k < 5; k++) begin
      if ((base_idle + k < a_idle_q.size()) && (a_idle_q[base_idle + k] != 1)) flag = 1'b1;
    end
    check_val("wo_idle_gap", flag, 1'b0);

    // Asynchronous reset during WR_RUN, then a stray done in IDLE
    @(negedge clk);
    wr_req = 1'b1;
    n = 0;
    while (!ifa.m_wr_start && (n < 50)) begin @(negedge clk); n++; end
    while (ifa.m_wr_start && (n < 100)) begin @(negedge clk); n++; end
    wr_req = 1'b0;
    check_val("mid_wait", (n < 100) && busy_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", busy_a, 1'b0);
    check_val("mid_rst_cnt", wcnt_a, 16'd0);
    check_val("mid_rst_rdy", wr_rdy_a, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    flag  = 1'b0;
    n     = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ifa.m_wr_done) n = 1;
      if (busy_a) flag = 1'b1;
    end
    check_val("stray_done_seen", n, 1);
    check_val("stray_done_cnt", wcnt_a, 16'd0);
    check_val("stray_done_busy", flag, 1'b0);

    // Timeout on B: read master never finishes
    mode[3] = 1;
    rd_req  = 1'b1;
    n = 0;
    while (!ifb.m_rd_start && (n < 20)) begin @(negedge clk); n++; end
    check_val("to_grant_wait", n < 20, 1'b1);
    repeat (15) @(negedge clk);
    check_val("to_start_held", {ifb.m_rd_start, err_b}, 2'b10);
    @(negedge clk);
    rd_req = 1'b0;
    check_val("to_abort", {ifb.m_rd_start, err_b, busy_b}, 3'b010);
    check_val("to_rd_cnt", rcnt_b, 4'd0);
    err_clr = 1'b1;
    #1;
    check_val("to_err_hold", err_b, 1'b1);
    @(negedge clk);
    err_clr = 1'b0;
    check_val("to_err_clr", err_b, 1'b0);

    // Saturation on B: 17 write bursts into a 4-bit counter
    base_g = b_wr_grants;
    wr_req = 1'b1;
    n = 0;
    while (((b_wr_grants - base_g) < 17) && (n < 2000)) begin @(negedge clk); n++; end
    while (busy_b && (n < 2100)) begin @(negedge clk); n++; end
    wr_req = 1'b0;
    check_val("sat_wait", n < 2100, 1'b1);
    check_val("sat_ngrants", b_wr_grants - base_g, 17);
    check_val("sat_cnt", wcnt_b, 4'hF);
    check_val("sat_no_err", err_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/axi_rw_arbiter.md
Name: axi_rw_arbiter

Overview:
Time-shares the single DDR3 AXI port between the AXI write master and the AXI read master. Burst requests from the FIFO-side controller (wr/rd start plus ready handshake) pass through this block. It grants one burst at a time with round-robin fairness and forwards start to the selected master. It also watches completion with a timeout, and gates all traffic until memory calibration is complete.

Parameters:
TIMEOUT_CYC, 4096, cycles allowed from grant to done before abort (range 16..65535)
CNT_W, 16, width of the saturating per-direction burst counters

Ports:
clk  in  1  AXI master clock
rst_n  in  1  asynchronous, active-low reset
calib_done  in  1  memory calibration complete; no grants while low
ctrl_wr_req  in  1  level write-burst request (controller's wr start)
ctrl_wr_ready  out  1  to controller; low while a write is granted/running
ctrl_rd_req  in  1  level read-burst request
ctrl_rd_ready  out  1  to controller; low while a read is granted/running
m_wr_start  out  1  start to AXI write master
m_wr_ready  in  1  write master idle/ready
m_wr_done  in  1  write master burst complete (1-cycle pulse)
m_rd_start  out  1  start to AXI read master
m_rd_ready  in  1  read master idle/ready
m_rd_done  in  1  read master burst complete (1-cycle pulse)
busy  out  1  state != IDLE
err_timeout  out  1  sticky timeout flag
err_clr  in  1  clears err_timeout
wr_burst_cnt  out  CNT_W  completed write bursts, saturating
rd_burst_cnt  out  CNT_W  completed read bursts, saturating

Behaviour:
- Reset (async, rst_n low): state IDLE, last_grant=RD (write wins first tie), all start outputs 0, busy 0, err_timeout 0, counters 0, timer 0. ctrl_*_ready follow their combinational equations.
- ctrl_wr_ready = calib_done & ~(state==WR_START|WR_RUN). ctrl_rd_ready is the same for RD states. Each is combinational, so a non-granted requester keeps its request pending.
- States:
  - IDLE:
    - No grant if calib_done=0.
    - Requests eligible only while the corresponding m_*_ready=1.
    - wr only -> WR_START; rd only -> RD_START.
    - Both -> the direction != last_grant; last_grant updates on entry.
  - WR_START:
    - m_wr_start=1 (registered; high the cycle after the request is sampled in IDLE).
    - m_wr_ready=0 -> WR_RUN and m_wr_start drops the same edge.
    - m_wr_done=1 -> IDLE (early completion).
  - WR_RUN: m_wr_start=0; m_wr_done=1 -> IDLE, wr_burst_cnt+1 (saturates at all-ones).
  - RD_START / RD_RUN: mirror of the write states with the rd signals and rd_burst_cnt.
- Latency: request sampled at edge N -> m_*_start high after edge N+1. done at edge M -> IDLE after M+1. Minimum one IDLE cycle between consecutive grants.
- Timer:
  - Cleared on every entry to a START state; increments each cycle in START/RUN.
  - Reaching TIMEOUT_CYC-1 without done: force IDLE, deassert start, set err_timeout, do not increment the burst counter, keep last_grant updated.
- err_timeout:
  - Clears only on err_clr=1.
  - err_clr and a timeout in the same cycle -> err_timeout=1 (set wins).
- done from the non-granted master or in IDLE: ignored, no state or counter change.
- calib_done dropping mid-burst: the current burst completes normally; no new grants until it returns high.
- Reset mid-burst: arbiter returns to IDLE immediately; the masters are not aborted (system reset covers them).

Decomposition:
- Shared package axi_arb_pkg:
  - state encoding localparams (IDLE=0, WR_START=1, WR_RUN=2, RD_START=3, RD_RUN=4, 3-bit);
  - direction constants DIR_WR=0, DIR_RD=1.
- One natural sub-module: arb_timeout_timer (load/enable/expire, width from TIMEOUT_CYC via clog2).
- Counters and FSM stay inline.

Test Plan:
- calib_done=0, both requests high 100 cycles -> no m_*_start, ctrl_*_ready=0. Raise calib_done -> m_wr_start high 2 edges later.
- Both requests held, each master responds ready-low 2 cycles after start and done 20 cycles later -> grants alternate W,R,W,R; wr_burst_cnt=rd_burst_cnt=2 after 4 bursts.
- Write only, 5 bursts -> 5 back-to-back write grants, each separated by exactly 1 IDLE cycle; ctrl_rd_ready stays 1.
- TIMEOUT_CYC=16, read master never asserts done -> m_rd_start drops and err_timeout=1 at cycle 16 after grant; rd_burst_cnt unchanged. Then err_clr pulse -> err_timeout=0.
- rst_n low during WR_RUN -> outputs reset asynchronously. A stray m_wr_done in IDLE -> no count change.
- CNT_W=4, 17 write bursts -> wr_burst_cnt saturates at 15.
